// File: rtl/eth_axis_hdr_rx_pkg.sv
// Shared Ethernet header constants, parser state and payload beat layout.
package eth_pkg;
  localparam int ETH_HDR_BYTES = 14;
  localparam int DEST_OFS      = 0;
  localparam int SRC_OFS       = 6;
  localparam int TYPE_OFS      = 12;

  typedef enum logic {S_HDR = 1'b0, S_PAYLOAD = 1'b1} rx_state_e;

  typedef struct packed {
    logic [7:0] tdata;
    logic       tlast;
    logic       tuser;
  } axis_beat_t;
endpackage

// File: rtl/eth_axis_hdr_rx_if.sv
// 8-bit AXI-stream byte bus with tlast/tuser sideband.
interface eth_axis_hdr_rx_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_axis_hdr_rx_axis_reg_1.sv
// One-entry valid/ready register slice; full throughput when out_ready is held high.
module axis_reg_1 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  assign in_ready = out_ready || !out_valid;

  // Whenever the slot is free or draining, it takes whatever is offered (or empties).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end
endmodule

// File: rtl/eth_axis_hdr_rx.sv
// Ethernet RX header stripper: splits a MAC byte stream into header fields
// (valid/ready) and a payload byte stream.
module eth_axis_hdr_rx
  import eth_pkg::*;
#(
  parameter int HDR_BYTES = ETH_HDR_BYTES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  eth_axis_hdr_rx_if.slave         s_axis,
  output logic                     m_eth_hdr_valid,
  input  logic                     m_eth_hdr_ready,
  output logic [47:0]              m_eth_dest_mac,
  output logic [47:0]              m_eth_src_mac,
  output logic [15:0]              m_eth_type,
  eth_axis_hdr_rx_if.master        m_eth_payload,
  output logic                     busy,
  output logic                     error_header_early_termination
);
  localparam logic [3:0] HDR_LAST = 4'(HDR_BYTES - 1);

  rx_state_e  state;
  logic [3:0] hdr_cnt;
  logic [7:0] hdr_b [HDR_BYTES];
  logic       run;
  logic       hdr_acc, pay_in_vld, pay_in_rdy, pay_acc;
  axis_beat_t pay_in, pay_out;

  // run keeps tready low while reset is asserted so every output reads 0.
  assign hdr_acc    = run && (state == S_HDR) && s_axis.tvalid && !m_eth_hdr_valid;
  assign pay_in_vld = run && (state == S_PAYLOAD) && s_axis.tvalid;
  assign pay_acc    = pay_in_vld && pay_in_rdy;
  assign s_axis.tready = run && ((state == S_HDR) ? !m_eth_hdr_valid : pay_in_rdy);
  assign pay_in     = {s_axis.tdata, s_axis.tlast, s_axis.tuser};

  assign m_eth_dest_mac = {hdr_b[DEST_OFS], hdr_b[DEST_OFS+1], hdr_b[DEST_OFS+2],
                           hdr_b[DEST_OFS+3], hdr_b[DEST_OFS+4], hdr_b[DEST_OFS+5]};
  assign m_eth_src_mac  = {hdr_b[SRC_OFS], hdr_b[SRC_OFS+1], hdr_b[SRC_OFS+2],
                           hdr_b[SRC_OFS+3], hdr_b[SRC_OFS+4], hdr_b[SRC_OFS+5]};
  assign m_eth_type     = {hdr_b[TYPE_OFS], hdr_b[TYPE_OFS+1]};
  assign busy           = (state == S_PAYLOAD) || (hdr_cnt != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run                            <= 1'b0;
      state                          <= S_HDR;
      hdr_cnt                        <= 4'd0;
      m_eth_hdr_valid                <= 1'b0;
      error_header_early_termination <= 1'b0;
      for (int i = 0; i < HDR_BYTES; i++) hdr_b[i] <= 8'h00;
    end else begin
      run                            <= 1'b1;
      error_header_early_termination <= 1'b0;
      if (m_eth_hdr_valid && m_eth_hdr_ready) m_eth_hdr_valid <= 1'b0;
      // Fields only load while hdr_valid is low, so they are stable while presented.
      if (hdr_acc) begin
        hdr_b[hdr_cnt] <= s_axis.tdata;
        if (s_axis.tlast) begin
          error_header_early_termination <= 1'b1;
          hdr_cnt                        <= 4'd0;
        end else if (hdr_cnt == HDR_LAST) begin
          m_eth_hdr_valid <= 1'b1;
          hdr_cnt         <= 4'd0;
          state           <= S_PAYLOAD;
        end else begin
          hdr_cnt <= hdr_cnt + 4'd1;
        end
      end
      if (pay_acc && s_axis.tlast) state <= S_HDR;
    end
  end

  axis_reg_1 #(.W($bits(axis_beat_t))) u_pay_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (pay_in),
    .in_valid  (pay_in_vld),
    .in_ready  (pay_in_rdy),
    .out_data  (pay_out),
    .out_valid (m_eth_payload.tvalid),
    .out_ready (m_eth_payload.tready)
  );

  assign m_eth_payload.tdata = pay_out.tdata;
  assign m_eth_payload.tlast = pay_out.tlast;
  assign m_eth_payload.tuser = pay_out.tuser;
endmodule

// File: tb/tb_eth_axis_hdr_rx.sv
// Bench for eth_axis_hdr_rx: frame-level reference model feeding header/payload scoreboards.
module tb_eth_axis_hdr_rx;
  import eth_pkg::*;

  typedef logic [7:0] byte_q_t [$];
  typedef struct { logic [7:0] d; logic l; logic u; int f; } pay_t;
  typedef struct { logic [47:0] dst; logic [47:0] src; logic [15:0] typ; } hdr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  eth_axis_hdr_rx_if s_axis ();
  eth_axis_hdr_rx_if m_pay ();
  logic        hdr_valid, hdr_ready;
  logic [47:0] dest, src;
  logic [15:0] etype;
  logic        busy, err;

  eth_axis_hdr_rx dut (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .s_axis                         (s_axis),
    .m_eth_hdr_valid                (hdr_valid),
    .m_eth_hdr_ready                (hdr_ready),
    .m_eth_dest_mac                 (dest),
    .m_eth_src_mac                  (src),
    .m_eth_type                     (etype),
    .m_eth_payload                  (m_pay),
    .busy                           (busy),
    .error_header_early_termination (err)
  );

  pay_t exp_pay [$];
  hdr_t exp_hdr [$];
  pay_t mon_p;
  hdr_t mon_h;
  int   n_cmp = 0, n_bad = 0;
  int   exp_err = 0, got_err = 0, got_beats = 0, got_hdrs = 0;
  logic f7_user = 1'b0;

  // Scoreboard monitor: sampled mid-cycle, where handshakes are stable.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err) got_err++;
      if (m_pay.tvalid && m_pay.tready) begin
        got_beats++;
        n_cmp++;
        if (exp_pay.size() == 0) begin
          n_bad++;
          $display("FAIL payload_extra got d=%h l=%b u=%b, want no beat", m_pay.tdata, m_pay.tlast, m_pay.tuser);
        end else begin
          mon_p = exp_pay.pop_front();
          if ({m_pay.tdata, m_pay.tlast, m_pay.tuser} !== {mon_p.d, mon_p.l, mon_p.u}) begin
            n_bad++;
            $display("FAIL payload_beat frame %0d got d=%h l=%b u=%b, want d=%h l=%b u=%b",
                     mon_p.f, m_pay.tdata, m_pay.tlast, m_pay.tuser, mon_p.d, mon_p.l, mon_p.u);
          end
          if (mon_p.f == 7 && mon_p.l) f7_user = m_pay.tuser;
        end
      end
      if (hdr_valid && hdr_ready) begin
        got_hdrs++;
        n_cmp++;
        if (exp_hdr.size() == 0) begin
          n_bad++;
          $display("FAIL header_extra got %h %h %h, want no header", dest, src, etype);
        end else begin
          mon_h = exp_hdr.pop_front();
          if ({dest, src, etype} !== {mon_h.dst, mon_h.src, mon_h.typ}) begin
            n_bad++;
            $display("FAIL header_fields got %h/%h/%h, want %h/%h/%h",
                     dest, src, etype, mon_h.dst, mon_h.src, mon_h.typ);
          end
        end
      end
    end
  end

  // Frame-level reference: short frames are errors, longer ones yield a header and payload.
  task automatic model_frame(input byte_q_t b, input bit user, input int fid);
    hdr_t h;
    pay_t p;
    if (b.size() <= ETH_HDR_BYTES) begin
      exp_err++;
    end else begin
      h.dst = {b[0], b[1], b[2], b[3], b[4], b[5]};
      h.src = {b[6], b[7], b[8], b[9], b[10], b[11]};
      h.typ = {b[12], b[13]};
      exp_hdr.push_back(h);
      for (int i = ETH_HDR_BYTES; i < b.size(); i++) begin
        p.d = b[i];
        p.l = (i == b.size() - 1);
        p.u = p.l ? user : 1'b0;
        p.f = fid;
        exp_pay.push_back(p);
      end
    end
  endtask

  task automatic rand_frame(output byte_q_t b, input int len);
    b = {};
    for (int i = 0; i < len; i++) b.push_back(8'($urandom));
  endtask

  // Sends bytes [first, last_x) of a frame; returns at posedge+1 after the last accept.
  task automatic send_range(input byte_q_t b, input bit user, input bit gaps,
                            input int first, input int last_x);
    int  w;
    bit  acc;
    for (int i = first; i < last_x && i < b.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_axis.tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      s_axis.tdata  = b[i];
      s_axis.tlast  = (i == b.size() - 1);
      s_axis.tuser  = s_axis.tlast ? user : 1'b0;
      s_axis.tvalid = 1'b1;
      w = 0;
      acc = 1'b0;
      while (!acc) begin
        @(negedge clk);
        acc = s_axis.tready;
        @(posedge clk);
        #1;
        w++;
        if (!acc && w > 2000) begin
          n_cmp++;
          n_bad++;
          $display("FAIL send_timeout byte %0d got tready=0, want accept", i);
          s_axis.tvalid = 1'b0;
          return;
        end
      end
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    s_axis.tuser  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int w = 0;
    while ((exp_pay.size() != 0 || exp_hdr.size() != 0) && w < 5000) begin
      @(posedge clk);
      w++;
    end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_pay.size() != 0 || exp_hdr.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain got pending pay=%0d hdr=%0d, want 0/0", tag, exp_pay.size(), exp_hdr.size());
    end
  endtask

  task automatic test_reset();
    s_axis.tvalid = 0; s_axis.tdata = 0; s_axis.tlast = 0; s_axis.tuser = 0;
    m_pay.tready = 1; hdr_ready = 1;
    #3 rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({hdr_valid, dest, src, etype, busy, err} !== '0) begin
      n_bad++;
      $display("FAIL reset_hdr got v=%b %h %h %h busy=%b err=%b, want all 0", hdr_valid, dest, src, etype, busy, err);
    end
    n_cmp++;
    if ({m_pay.tvalid, m_pay.tdata, m_pay.tlast, m_pay.tuser, s_axis.tready} !== '0) begin
      n_bad++;
      $display("FAIL reset_stream got pv=%b pd=%h pl=%b pu=%b srdy=%b, want all 0",
               m_pay.tvalid, m_pay.tdata, m_pay.tlast, m_pay.tuser, s_axis.tready);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (s_axis.tready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release got tready=%b busy=%b, want 1/0", s_axis.tready, busy);
    end
  endtask

  task automatic test_arp();
    byte_q_t b;
    int beats0 = got_beats, err0 = got_err;
    b = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h08, 8'h06};
    for (int i = 0; i < 28; i++) b.push_back(8'(i));
    m_pay.tready = 1; hdr_ready = 1;
    model_frame(b, 1'b0, -1);
    send_range(b, 1'b0, 1'b0, 0, 14);
    n_cmp++;
    if (hdr_valid !== 1'b1 || dest !== 48'hFFFFFFFFFFFF || src !== 48'h020000000001 || etype !== 16'h0806) begin
      n_bad++;
      $display("FAIL arp_header got v=%b %h %h %h, want 1 ffffffffffff 020000000001 0806", hdr_valid, dest, src, etype);
    end
    send_range(b, 1'b0, 1'b0, 14, b.size());
    wait_drain("arp");
    n_cmp++;
    if (got_beats - beats0 != 28 || got_err != err0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL arp_counts got beats=%0d errs=%0d busy=%b, want 28/0/0", got_beats - beats0, got_err - err0, busy);
    end
  endtask

  task automatic test_early_term();
    byte_q_t a, c;
    int beats0 = got_beats, err0 = got_err, hdr0 = got_hdrs;
    rand_frame(a, 10);
    rand_frame(c, 14);
    model_frame(a, 1'b0, -2);
    model_frame(c, 1'b1, -3);
    send_range(a, 1'b0, 1'b0, 0, a.size());
    send_range(c, 1'b1, 1'b0, 0, c.size());
    wait_drain("early");
    n_cmp++;
    if (got_err - err0 != 2 || got_err != exp_err) begin
      n_bad++;
      $display("FAIL early_err_pulses got %0d (total %0d), want 2 (total %0d)", got_err - err0, got_err, exp_err);
    end
    n_cmp++;
    if (got_hdrs != hdr0 || got_beats != beats0 || hdr_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL early_quiet got hdrs=%0d beats=%0d v=%b busy=%b, want 0/0/0/0",
               got_hdrs - hdr0, got_beats - beats0, hdr_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    byte_q_t a, c;
    int stall_bad = 0, hold_bad = 0, hdr0 = got_hdrs;
    rand_frame(a, 20);
    rand_frame(c, 30);
    m_pay.tready = 1; hdr_ready = 0;
    model_frame(a, 1'b0, -4);
    model_frame(c, 1'b0, -5);
    send_range(a, 1'b0, 1'b0, 0, a.size());
    s_axis.tdata = c[0]; s_axis.tlast = 1'b0; s_axis.tuser = 1'b0; s_axis.tvalid = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (s_axis.tready !== 1'b0) stall_bad++;
      if (hdr_valid !== 1'b1) hold_bad++;
    end
    n_cmp++;
    if (stall_bad != 0) begin
      n_bad++;
      $display("FAIL b2b_stall got tready high %0d of 40 cycles, want 0", stall_bad);
    end
    n_cmp++;
    if (hold_bad != 0) begin
      n_bad++;
      $display("FAIL b2b_hdr_hold got hdr_valid low %0d of 40 cycles, want 0", hold_bad);
    end
    @(posedge clk);
    #1 hdr_ready = 1;
    send_range(c, 1'b0, 1'b0, 0, c.size());
    wait_drain("b2b");
    n_cmp++;
    if (got_hdrs - hdr0 != 2) begin
      n_bad++;
      $display("FAIL b2b_headers got %0d, want 2", got_hdrs - hdr0);
    end
  endtask

  task automatic test_random();
    bit done = 1'b0;
    int hdr0 = got_hdrs, err0 = got_err;
    f7_user = 1'b0;
    fork
      begin
        for (int f = 0; f < 100; f++) begin
          byte_q_t b;
          int  len;
          bit  user;
          len  = (f == 3) ? 1514 : (f == 50) ? 15 : $urandom_range(15, 80);
          user = (f == 7) ? 1'b1 : ($urandom_range(0, 7) == 0);
          rand_frame(b, len);
          model_frame(b, user, f);
          send_range(b, user, 1'b1, 0, len);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          m_pay.tready = 1'($urandom);
          hdr_ready    = 1'($urandom);
        end
      end
    join
    m_pay.tready = 1; hdr_ready = 1;
    wait_drain("random");
    n_cmp++;
    if (got_hdrs - hdr0 != 100 || got_err != err0) begin
      n_bad++;
      $display("FAIL random_counts got hdrs=%0d errs=%0d, want 100/0", got_hdrs - hdr0, got_err - err0);
    end
    n_cmp++;
    if (f7_user !== 1'b1) begin
      n_bad++;
      $display("FAIL random_frame7_tuser got %b, want 1", f7_user);
    end
  endtask

  task automatic test_reset_mid();
    byte_q_t a, c;
    int hdr0, beats0;
    rand_frame(a, 60);
    m_pay.tready = 1; hdr_ready = 1;
    model_frame(a, 1'b0, -6);
    send_range(a, 1'b0, 1'b0, 0, 14 + 21);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({hdr_valid, dest, src, etype, busy, err} !== '0) begin
      n_bad++;
      $display("FAIL midreset_hdr got v=%b %h %h %h busy=%b err=%b, want all 0", hdr_valid, dest, src, etype, busy, err);
    end
    n_cmp++;
    if ({m_pay.tvalid, m_pay.tdata, m_pay.tlast, m_pay.tuser, s_axis.tready} !== '0) begin
      n_bad++;
      $display("FAIL midreset_stream got pv=%b pd=%h pl=%b pu=%b srdy=%b, want all 0",
               m_pay.tvalid, m_pay.tdata, m_pay.tlast, m_pay.tuser, s_axis.tready);
    end
    exp_pay.delete();
    exp_hdr.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    hdr0 = got_hdrs;
    beats0 = got_beats;
    rand_frame(c, 40);
    model_frame(c, 1'b1, -7);
    send_range(c, 1'b1, 1'b0, 0, c.size());
    wait_drain("midreset");
    n_cmp++;
    if (got_hdrs - hdr0 != 1 || got_beats - beats0 != 26) begin
      n_bad++;
      $display("FAIL midreset_fresh got hdrs=%0d beats=%0d, want 1/26", got_hdrs - hdr0, got_beats - beats0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got no finish by 3ms, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arp();
    test_early_term();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/eth_axis_hdr_rx.md
Name: eth_axis_hdr_rx

Overview:
- Sits directly downstream of the 1G MAC receive path.
- Consumes the MAC's 8-bit AXI-stream receive frames, starting at the destination MAC address.
- Strips the 14-byte Ethernet header into parallel fields with a valid/ready handshake.
- Forwards the remaining payload bytes as a separate 8-bit AXI stream to the IP/ARP layers.

Parameters:
- HDR_BYTES, 14, header length in bytes. Fixed; exists for readability only and must not be overridden.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  8  frame bytes from MAC.
- s_axis_tvalid  in  1  input byte valid.
- s_axis_tready  out  1  input byte accepted when tvalid&&tready.
- s_axis_tlast  in  1  last byte of frame.
- s_axis_tuser  in  1  frame bad; meaningful with tlast.
- m_eth_hdr_valid  out  1  header fields valid.
- m_eth_hdr_ready  in  1  header consumed.
- m_eth_dest_mac  out  48  bytes 0-5, byte 0 in bits 47:40.
- m_eth_src_mac  out  48  bytes 6-11, byte 6 in bits 47:40.
- m_eth_type  out  16  bytes 12-13, byte 12 in bits 15:8.
- m_eth_payload_tdata  out  8  payload byte.
- m_eth_payload_tvalid  out  1  payload valid.
- m_eth_payload_tready  in  1  payload accepted.
- m_eth_payload_tlast  out  1  last payload byte.
- m_eth_payload_tuser  out  1  copied from s_axis_tuser.
- busy  out  1  high while in S_PAYLOAD or while hdr_cnt != 0.
- error_header_early_termination  out  1  one-cycle pulse.

Behaviour:
- Interface decided: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: every output is 0, including all header field registers; state is S_HDR; hdr_cnt is 0.
- Transfer rule: a transfer occurs only when valid && ready. Data is sampled on the clk edge.
- S_HDR:
  - s_axis_tready = !m_eth_hdr_valid.
  - Each accepted byte is written into the field selected by hdr_cnt (4-bit, 0..13).
  - hdr_cnt increments on each accepted byte.
- Header completion: byte with hdr_cnt==13 accepted and tlast=0:
  - m_eth_hdr_valid=1 on the next cycle.
  - hdr_cnt returns to 0; state moves to S_PAYLOAD.
- Early termination: tlast=1 accepted while in S_HDR, at any hdr_cnt 0..13 (13 included):
  - header discarded, m_eth_hdr_valid stays 0.
  - error_header_early_termination pulses high for exactly one cycle after the accepting edge.
  - hdr_cnt resets to 0; state stays S_HDR.
  - A zero-length payload counts as early termination.
- m_eth_hdr_valid holds with fields stable until m_eth_hdr_ready; it clears on the cycle after the handshake.
  - Header fields must not change while valid.
  - The payload may flow while the header is still pending.
- S_PAYLOAD, one-entry output register:
  - s_axis_tready = m_eth_payload_tready || !m_eth_payload_tvalid.
  - An accepted input byte loads tdata/tlast/tuser into the output register; tvalid=1 on the next cycle. Latency is 1 cycle.
  - Output clears on handshake unless reloaded in the same cycle.
  - Simultaneous output handshake and input accept keeps tvalid=1 with the new byte, giving full throughput of 1 byte/cycle.
- End of frame: an accepted byte with tlast=1 in S_PAYLOAD sends the state to S_HDR on the next cycle.
  - The next frame's header waits only for m_eth_hdr_valid==0, so there is no bubble when the header is already consumed.
- tuser is forwarded unchanged, with no drop. tuser during S_HDR with tlast is handled by the early-termination rule.
- tvalid low mid-frame: no state change, counters hold.
- Reset mid-frame: all state is cleared immediately. The next accepted byte is treated as dest MAC byte 0.

Decomposition:
- Shared package eth_pkg:
  - ETH_HDR_BYTES=14.
  - Byte-offset constants DEST_OFS=0, SRC_OFS=6, TYPE_OFS=12.
  - State encoding localparams S_HDR, S_PAYLOAD.
- Sub-module axis_reg_1 holds the one-entry payload output register (valid/ready register slice). It is reusable by the matching tx header-insert stage.

Test Plan:
- Frame dest=FF:FF:FF:FF:FF:FF, src=02:00:00:00:00:01, type=0x0806, 28 payload bytes 0x00..0x1B, all ready high:
  - hdr_valid 1 cycle after byte 13, with dest=48'hFFFFFFFFFFFF, src=48'h020000000001, type=16'h0806.
  - 28 payload beats with tlast on 0x1B.
  - No error pulse.
- 10-byte frame with tlast on byte 9, then a 14-byte frame with tlast on byte 13:
  - Two error_header_early_termination pulses.
  - hdr_valid never asserts, no payload beats.
  - busy returns to 0.
- Back-to-back frames with m_eth_hdr_ready held 0 for 40 cycles:
  - s_axis_tready low from the second frame's first byte until the first header handshake.
  - The second header matches its stimulus exactly.
- Random tvalid gaps and random payload tready (50%) over 100 frames of 15-1514 bytes:
  - Payload byte sequence and tlast positions match the scoreboard.
  - tuser=1 on the last byte of frame 7 appears on that frame's last payload beat.
- rst_n asserted asynchronously at payload byte 20:
  - All outputs 0 immediately.
  - After release, a fresh frame parses correctly with hdr_cnt starting at 0.
